// File: rtl/mem_arb_pkg.sv
// Shared types and default tuning for the fetch/data unified-memory arbiter.
// No logic; imported by the arbiter top and its priority sub-block.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IF = 2'd1,
    WAIT_D  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam int unsigned D_STREAK_DEF = 4;
  localparam int unsigned TIMEOUT_DEF  = 15;

endpackage

// File: rtl/arb_prio.sv
// Fetch/data grant decision: data by default, fetch after D_STREAK data wins in a row.
// Combinational grant, one-register streak state; grants only while arb_en is high.
module arb_prio
  import mem_arb_pkg::*;
#(
  parameter int unsigned D_STREAK = D_STREAK_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic d_req,
  input  logic arb_en,
  output logic grant_if,
  output logic grant_d
);

  localparam int SW = $clog2(D_STREAK + 1);

  logic [SW-1:0] streak;
  logic          fetch_turn;

  always_comb begin
    fetch_turn = (streak == SW'(D_STREAK));
    grant_if   = arb_en & if_req & (~d_req | fetch_turn);
    grant_d    = arb_en & d_req & ~grant_if;
  end

  // Streak only counts data wins that actually starved a waiting fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak <= '0;
    end else if (!if_req || grant_if) begin
      streak <= '0;
    end else if (grant_d && !fetch_turn) begin
      streak <= streak + SW'(1);
    end
  end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port memory between fetch and MEM; one access in flight, data-first priority.
// Latency req->valid is 2 cycles plus memory delay; requesters are stalled until their valid pulse.
module imem_dmem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned D_STREAK = D_STREAK_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [3:0]    d_be,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_be,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rvalid,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state, state_nxt;
  owner_t        owner;
  logic [TW-1:0] tcnt;
  logic          arb_en, grant_if, grant_d;
  logic          rsp_done, tmo, tmo_edge;

  arb_prio #(.D_STREAK(D_STREAK)) u_prio (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .d_req    (d_req),
    .arb_en   (arb_en),
    .grant_if (grant_if),
    .grant_d  (grant_d)
  );

  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = d_req & ~d_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // A requester still shows its old req during its valid cycle, so skip arbitration then.
  always_comb begin
    state_nxt = state;
    arb_en    = 1'b0;
    rsp_done  = 1'b0;
    tmo       = 1'b0;
    tmo_edge  = (tcnt == TW'(TIMEOUT - 1));
    case (state)
      IDLE: begin
        arb_en = ~if_valid & ~d_valid;
        if (grant_d)       state_nxt = WAIT_D;
        else if (grant_if) state_nxt = WAIT_IF;
      end
      WAIT_IF, WAIT_D: begin
        rsp_done = mem_rvalid | tmo_edge;
        tmo      = ~mem_rvalid & tmo_edge;
        if (rsp_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      owner     <= OWN_IF;
      tcnt      <= '0;
      if_valid  <= 1'b0;
      if_rdata  <= '0;
      d_valid   <= 1'b0;
      d_rdata   <= '0;
      err       <= 1'b0;
    end else begin
      mem_req  <= 1'b0;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;

      if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_be    <= d_be;
        owner     <= OWN_D;
      end else if (grant_if) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_be    <= 4'b1111;
        owner     <= OWN_IF;
      end

      if (state == IDLE)              tcnt <= '0;
      else if (tcnt != TW'(TIMEOUT))  tcnt <= tcnt + TW'(1);

      // An aborted access still completes towards the owner, with zero data.
      if (rsp_done) begin
        if (owner == OWN_IF) begin
          if_valid <= 1'b1;
          if_rdata <= tmo ? '0 : mem_rdata;
        end else begin
          d_valid <= 1'b1;
          d_rdata <= tmo ? '0 : mem_rdata;
        end
      end

      if (tmo) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Scoreboard bench for imem_dmem_arbiter: directed corner cases, then random fetch/data traffic.
module tb_imem_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_valid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_valid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        mem_req, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        stall_if, stall_mem, err;

  always #5 clk = ~clk;

  imem_dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Fetch image 0x00-0x1C (read-only), data region 0x20-0x3C.
  logic [31:0] imem   [8];
  logic [31:0] dm     [8];
  logic [31:0] ref_dm [8];
  logic [31:0] exp_if_q [$];
  logic [31:0] exp_d_q  [$];
  bit          grant_log [$];   // 1 = fetch grant

  int          mem_force_w = -1; // -1 random latency, 0 never answer, else WAIT cycle of response
  bit          pend;
  int          mcnt;
  logic [31:0] mresp;
  int          last_req_cyc, last_if_vcyc, last_d_vcyc, last_if_issue, last_d_issue;
  int          dv_count = 0;
  logic [31:0] cur_if_addr, cur_d_addr, cur_d_wdata;
  logic        cur_d_we;
  logic [3:0]  cur_d_be;
  bit          if_pend = 0, d_pend = 0;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = w[b*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Memory model: checks each issued request against what a requester has outstanding.
  initial begin
    int w, r;
    logic [2:0] idx;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    pend       = 1'b0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (mem_req) begin
        last_req_cyc = cyc;
        idx = mem_addr[4:2];
        checks++;
        if (mem_addr < 32'h20) begin
          grant_log.push_back(1'b1);
          if (!(if_pend && mem_addr == cur_if_addr && mem_we == 1'b0 && mem_be == 4'hF)) begin
            errors++;
            $display("FAIL fetch_issue addr=%h we=%b be=%b want addr=%h we=0 be=1111 pend=%0d",
                     mem_addr, mem_we, mem_be, cur_if_addr, if_pend);
          end
          mresp = imem[idx];
        end else begin
          grant_log.push_back(1'b0);
          if (!(d_pend && mem_addr == cur_d_addr && mem_we == cur_d_we && mem_be == cur_d_be &&
                (!cur_d_we || mem_wdata == cur_d_wdata))) begin
            errors++;
            $display("FAIL data_issue addr=%h we=%b be=%b wd=%h want addr=%h we=%b be=%b wd=%h",
                     mem_addr, mem_we, mem_be, mem_wdata, cur_d_addr, cur_d_we, cur_d_be, cur_d_wdata);
          end
          if (mem_we) dm[idx] = merge(dm[idx], mem_wdata, mem_be);
          mresp = dm[idx];
        end
        if (mem_force_w >= 0) w = mem_force_w;
        else begin
          r = $urandom_range(0, 9);
          w = (r == 0) ? 15 : (r == 1) ? 1 : $urandom_range(2, 6);
        end
        if (w > 0) begin
          pend = 1'b1;
          mcnt = w - 1;
        end
      end
      if (pend) begin
        if (mcnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mresp;
          pend       = 1'b0;
        end else mcnt--;
      end
    end
  end

  // Monitor: pops the scoreboard on every valid pulse and checks stall outputs each cycle.
  always @(negedge clk) begin
    if (rst) begin
      chk("stall_if", {31'b0, stall_if}, {31'b0, if_req & ~if_valid});
      chk("stall_mem", {31'b0, stall_mem}, {31'b0, d_req & ~d_valid});
      if (if_valid) begin
        last_if_vcyc = cyc;
        if (exp_if_q.size() == 0) chk("if_valid_unexpected", 32'd1, 32'd0);
        else chk("if_rdata", if_rdata, exp_if_q.pop_front());
      end
      if (d_valid) begin
        last_d_vcyc = cyc;
        dv_count++;
        if (exp_d_q.size() == 0) chk("d_valid_unexpected", 32'd1, 32'd0);
        else chk("d_rdata", d_rdata, exp_d_q.pop_front());
      end
    end
  end

  // Transactions start at posedge+1 and return at posedge+1 after the valid cycle.
  task automatic fetch_txn(input logic [31:0] a, input bit tmo_exp);
    logic [31:0] e;
    e = tmo_exp ? 32'h0 : imem[a[4:2]];
    if_addr = a; if_req = 1'b1; cur_if_addr = a; if_pend = 1'b1;
    last_if_issue = cyc;
    exp_if_q.push_back(e);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (if_valid) break;
    end
    if (!if_valid) chk("if_valid_timeout", 32'd0, 32'd1);
    if_pend = 1'b0;
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic data_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input bit tmo_exp);
    logic [31:0] e;
    if (we) ref_dm[a[4:2]] = merge(ref_dm[a[4:2]], wd, be);
    e = tmo_exp ? 32'h0 : ref_dm[a[4:2]];
    d_we = we; d_addr = a; d_wdata = wd; d_be = be; d_req = 1'b1;
    cur_d_we = we; cur_d_addr = a; cur_d_wdata = wd; cur_d_be = be; d_pend = 1'b1;
    last_d_issue = cyc;
    exp_d_q.push_back(e);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (d_valid) break;
    end
    if (!d_valid) chk("d_valid_timeout", 32'd0, 32'd1);
    d_pend = 1'b0;
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic rand_data();
    data_txn(1'($urandom_range(0, 1)), 32'h20 + 32'($urandom_range(0, 7)) * 4, $urandom,
             4'($urandom_range(1, 15)), 1'b0);
  endtask

  task automatic gap();
    int g;
    g = $urandom_range(0, 3);
    repeat (g) begin @(posedge clk); #1; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int dv0;
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    for (int i = 0; i < 8; i++) begin
      imem[i] = $urandom;
      dm[i]   = $urandom;
      ref_dm[i] = dm[i];
    end
    imem[4] = 32'h00500093;
    repeat (3) @(posedge clk); #1;
    chk("reset_outputs", {31'b0, |{mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_valid,
                                   d_valid, if_rdata, d_rdata, err}}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of WAIT_D; the late response must be dropped.
    mem_force_w = 4;
    d_we = 1'b0; d_addr = 32'h24; d_wdata = '0; d_be = 4'hF; d_req = 1'b1;
    cur_d_we = 1'b0; cur_d_addr = 32'h24; cur_d_wdata = '0; cur_d_be = 4'hF; d_pend = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (mem_req) break;
    end
    chk("rst_test_mem_req", {31'b0, mem_req}, 32'd1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("async_reset_outputs", {31'b0, |{mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_valid,
                                         d_valid, if_rdata, d_rdata, err}}, 32'd0);
    d_req = 1'b0; d_pend = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    dv0 = dv_count;
    repeat (8) begin @(posedge clk); #1; end
    chk("no_d_valid_after_reset", dv_count - dv0, 32'd0);

    // Single fetch with a one-cycle memory.
    mem_force_w = 2;
    fetch_txn(32'h10, 1'b0);
    chk("fetch_mem_req_cycle", last_req_cyc - last_if_issue, 32'd1);
    chk("fetch_valid_cycle", last_if_vcyc - last_if_issue, 32'd3);

    // Simultaneous store + fetch, then sustained contention.
    mem_force_w = -1;
    grant_log.delete();
    fork
      begin fetch_txn(32'h00, 1'b0); fetch_txn(32'h04, 1'b0); end
      begin
        data_txn(1'b1, 32'h20, 32'hDEADBEEF, 4'b0011, 1'b0);
        repeat (7) rand_data();
      end
    join
    chk("grant_count", grant_log.size(), 32'd10);
    for (int i = 0; i < 10 && i < grant_log.size(); i++)
      chk($sformatf("grant_%0d_is_fetch", i), {31'b0, grant_log[i]}, {31'b0, (i % 5) == 4});

    // Response in the very last WAIT cycle is a normal completion.
    mem_force_w = 15;
    data_txn(1'b0, 32'h28, '0, 4'hF, 1'b0);
    chk("edge_rsp_err", {31'b0, err}, 32'd0);
    chk("edge_rsp_latency", last_d_vcyc - last_d_issue, 32'd16);

    // Random traffic from both requesters.
    mem_force_w = -1;
    fork
      begin
        repeat (40) begin gap(); fetch_txn(32'($urandom_range(0, 7)) * 4, 1'b0); end
      end
      begin
        repeat (40) begin gap(); rand_data(); end
      end
    join
    chk("random_err", {31'b0, err}, 32'd0);

    // Memory never answers: abort with zero data, err becomes sticky.
    mem_force_w = 0;
    data_txn(1'b0, 32'h2C, '0, 4'hF, 1'b1);
    chk("timeout_err", {31'b0, err}, 32'd1);
    chk("timeout_latency", last_d_vcyc - last_d_issue, 32'd16);
    mem_force_w = 2;
    fetch_txn(32'h08, 1'b0);
    chk("after_timeout_latency", last_if_vcyc - last_if_issue, 32'd3);
    chk("err_sticky", {31'b0, err}, 32'd1);

    repeat (2) @(posedge clk);
    chk("if_queue_empty", exp_if_q.size(), 32'd0);
    chk("d_queue_empty", exp_d_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
Shares one single-port unified memory between the fetch stage and the MEM stage of the 5-stage pipeline. It accepts the two request streams, grants one at a time, and tracks the outstanding access until the memory answers. It returns read data and a one-cycle valid pulse to the winner and produces stall outputs that feed the hazard unit (StallF/StallD for fetch, freeze of EX/MEM/WB for data).

Parameters:
AW, 32, address width
DW, 32, data width
D_STREAK, 4, max consecutive data grants while a fetch is pending
TIMEOUT, 15, cycles to wait for mem_rvalid before aborting

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous, active-low
if_req  input  1  fetch request; held high, address stable, until if_valid
if_addr  input  AW  fetch address (PCF)
if_rdata  output  DW  fetched instruction word
if_valid  output  1  one-cycle pulse, if_rdata valid
d_req  input  1  data request; held high with stable fields until d_valid
d_we  input  1  1 = store, 0 = load
d_addr  input  AW  data address (ALUResultM)
d_wdata  input  DW  store data (WriteDataM)
d_be  input  4  byte enables
d_rdata  output  DW  load data (raw word; LS_sel still extends it)
d_valid  output  1  one-cycle pulse, access complete
mem_req  output  1  one-cycle request pulse to memory
mem_we  output  1  write strobe, qualified by mem_req
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_be  output  4  memory byte enables
mem_rdata  input  DW  memory read data
mem_rvalid  input  1  response pulse for reads and writes
stall_if  output  1  fetch pending and not yet answered
stall_mem  output  1  data pending and not yet answered
err  output  1  sticky timeout flag, cleared only by reset

Behaviour:
- Reset (rst low, asynchronous): state IDLE. All outputs 0: mem_*, if_valid, d_valid, if_rdata, d_rdata, err. Streak counter and timeout counter 0. Any mem_rvalid arriving in IDLE is ignored.
- FSM states:
  - IDLE: if any request is pending, pick a winner. Register mem_req=1 plus that requester's addr/we/wdata/be, and latch the owner. Go to WAIT_IF or WAIT_D on the next edge.
  - WAIT_IF / WAIT_D: mem_req=0; mem_addr, mem_we, mem_wdata and mem_be hold their values. On mem_rvalid: register rdata into if_rdata or d_rdata, pulse the owner's valid for 1 cycle, return to IDLE.
- Latency: request seen in IDLE at edge N -> mem_req high in cycle N+1 -> valid pulse the cycle after mem_rvalid. Minimum 3 cycles with single-cycle memory. No back-to-back issue; IDLE is always visited for one cycle.
- Priority:
  - Data wins by default, because MEM is the older instruction.
  - Streak counter increments on each data grant made while if_req=1.
  - When streak == D_STREAK and if_req=1, fetch wins. Counter clears on any fetch grant or when if_req=0.
- Simultaneous d_req and if_req with streak < D_STREAK: data granted.
- Fetch write: never. mem_we=0 and mem_be=4'b1111 on fetch grants.
- Stall outputs are combinational: stall_if = if_req & ~if_valid; stall_mem = d_req & ~d_valid.
- Timeout:
  - Counter runs in WAIT states and saturates.
  - On reaching TIMEOUT without mem_rvalid: set err, pulse the owner's valid with rdata = 0, return to IDLE.
  - mem_rvalid arriving in the same cycle as timeout counts as a normal response; err is not set.
- A requester dropping req while in WAIT (pipeline flush) does not abort the access. The valid still pulses and the requester ignores it.
- rdata outputs hold their last value between pulses.

Decomposition:
- Shared package mem_arb_pkg: state enum (IDLE, WAIT_IF, WAIT_D), owner enum (OWN_IF, OWN_D), default D_STREAK/TIMEOUT constants.
- One sub-module: arb_prio, a combinational priority/streak decision plus the streak counter register. The top holds the FSM, request registers, and timeout counter.

Test Plan:
- Reset mid-WAIT_D (rst low one cycle while memory delay is 3) -> all outputs 0 immediately. The late mem_rvalid is ignored; no d_valid.
- Single fetch if_addr=0x10, memory returns 0x00500093 after 1 cycle -> mem_req at cycle 1, if_valid with if_rdata=0x00500093 at cycle 3; stall_if high cycles 0-2.
- if_req and d_req (store, d_addr=0x20, d_wdata=0xDEADBEEF, d_be=4'b0011) together -> data granted first with mem_we=1 and mem_be=4'b0011; fetch is issued after d_valid.
- Continuous d_req and if_req, D_STREAK=4 -> grant sequence D,D,D,D,IF,D,D,D,D,IF.
- Memory never responds -> err=1 and the owner's valid pulses with rdata=0 after TIMEOUT=15 WAIT cycles. The next request proceeds normally; err stays 1.
- mem_rvalid coincident with the timeout cycle -> normal completion with the returned data; err stays 0.
